// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: saturation mode encoding and
// the modulus-to-limit helper used by counters, prescalers and timers.
package counter_pkg;

  typedef enum logic {
    CNT_MODE_WRAP = 1'b0,
    CNT_MODE_SAT  = 1'b1
  } cnt_mode_e;

  // Largest legal count for a given modulus; callers keep the low WIDTH bits.
  function automatic logic [31:0] limit_of(input longint unsigned modulus);
    return 32'(modulus - 64'd1);
  endfunction

endpackage

// File: rtl/counter_next_logic.sv
// Combinational next-count and limit detection for an up/down counter
// running over 0..LIMIT, with wrap or saturate behaviour at the limits.
module counter_next_logic
  import counter_pkg::*;
#(
  parameter int unsigned       WIDTH = 4,
  parameter logic [WIDTH-1:0]  LIMIT = '1,
  parameter cnt_mode_e         MODE  = CNT_MODE_WRAP
) (
  input  logic [WIDTH-1:0] q,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q_next,
  output logic             at_limit
);

  always_comb begin
    at_limit = en & (up ? (q == LIMIT) : (q == '0));
    q_next   = q;
    if (en) begin
      if (at_limit) begin
        if (MODE == CNT_MODE_WRAP) begin
          q_next = up ? '0 : LIMIT;
        end
      end else begin
        q_next = up ? q + WIDTH'(1) : q - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with clear, clamped parallel load, wrap or
// saturate at the limits, combinational terminal count and registered ovf.
module updown_counter_mod
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH    = 4,
  parameter longint unsigned  MODULUS  = 16,
  parameter int unsigned      SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [31:0]      LIMIT_FULL = limit_of(MODULUS);
  localparam logic [WIDTH-1:0] LIMIT      = LIMIT_FULL[WIDTH-1:0];
  localparam cnt_mode_e        MODE       = (SATURATE != 0) ? CNT_MODE_SAT : CNT_MODE_WRAP;

  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $fatal(1, "updown_counter_mod: WIDTH must be 1..32");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
      $fatal(1, "updown_counter_mod: MODULUS must be 2..2**WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] step_q;
  logic             at_limit;
  logic [WIDTH-1:0] d_clamped;

  counter_next_logic #(
    .WIDTH (WIDTH),
    .LIMIT (LIMIT),
    .MODE  (MODE)
  ) u_next (
    .q        (q_q),
    .en       (en),
    .up       (up),
    .q_next   (step_q),
    .at_limit (at_limit)
  );

  always_comb begin
    d_clamped = (d > LIMIT) ? LIMIT : d;
    q_d       = q_q;
    ovf_d     = 1'b0;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = d_clamped;
    end else if (en) begin
      q_d   = step_q;
      ovf_d = at_limit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign q   = q_q;
  assign tc  = at_limit;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod: wrap and saturate counters at MODULUS=10 plus
// a MODULUS=16 pair cascaded through tc, checked against a reference model.
module tb_updown_counter_mod;

  typedef struct {
    int   idx;
    int   q;
    logic ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_i  [4];
  logic       load_i [4];
  logic [3:0] d_i    [4];
  logic       en_i   [4];
  logic       up_i   [4];
  logic [3:0] q_o    [4];
  logic       tc_o   [4];
  logic       ovf_o  [4];

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  int   mq   [4];
  logic movf [4];
  int   modv [4] = '{10, 10, 16, 16};
  bit   satv [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  always #5 clk = ~clk;

  updown_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .clr(clr_i[0]), .load(load_i[0]), .d(d_i[0]),
    .en(en_i[0]), .up(up_i[0]), .q(q_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]));

  updown_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .clr(clr_i[1]), .load(load_i[1]), .d(d_i[1]),
    .en(en_i[1]), .up(up_i[1]), .q(q_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]));

  updown_counter_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_lo (
    .clk(clk), .rst(rst), .clr(clr_i[2]), .load(load_i[2]), .d(d_i[2]),
    .en(en_i[2]), .up(up_i[2]), .q(q_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2]));

  updown_counter_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_hi (
    .clk(clk), .rst(rst), .clr(clr_i[3]), .load(load_i[3]), .d(d_i[3]),
    .en(tc_o[2]), .up(up_i[3]), .q(q_o[3]), .tc(tc_o[3]), .ovf(ovf_o[3]));

  // Checks tc against the model with the inputs now applied, then pushes the
  // post-edge state of every instance; the upper stage's enable is the lower tc.
  task automatic predict_all();
    logic etc2;
    etc2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic e, u, etc, nov;
      int   lim, nq;
      exp_t x;
      e   = (k == 3) ? etc2 : en_i[k];
      u   = up_i[k];
      lim = modv[k] - 1;
      etc = e && ((u && mq[k] == lim) || (!u && mq[k] == 0));
      if (k == 2) etc2 = etc;
      n_cmp++;
      if (tc_o[k] !== etc) begin
        n_err++;
        $display("FAIL tc inst%0d q=%0d: got %b expected %b", k, mq[k], tc_o[k], etc);
      end
      nq  = mq[k];
      nov = 1'b0;
      if (clr_i[k]) begin
        nq = 0;
      end else if (load_i[k]) begin
        nq = (int'(d_i[k]) > lim) ? lim : int'(d_i[k]);
      end else if (e) begin
        if (etc) begin
          nov = 1'b1;
          if (!satv[k]) nq = u ? 0 : lim;
        end else begin
          nq = u ? mq[k] + 1 : mq[k] - 1;
        end
      end
      mq[k]   = nq;
      movf[k] = nov;
      x.idx = k;
      x.q   = nq;
      x.ovf = nov;
      sb.push_back(x);
    end
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      n_cmp++;
      if (q_o[x.idx] !== 4'(x.q)) begin
        n_err++;
        $display("FAIL q inst%0d: got %0d expected %0d", x.idx, q_o[x.idx], x.q);
      end
      n_cmp++;
      if (ovf_o[x.idx] !== x.ovf) begin
        n_err++;
        $display("FAIL ovf inst%0d: got %b expected %b", x.idx, ovf_o[x.idx], x.ovf);
      end
    end
  endtask

  task automatic step(input int idx, input logic c, input logic l, input logic [3:0] dd,
                      input logic e, input logic u);
    @(negedge clk);
    clr_i[idx]  = c;
    load_i[idx] = l;
    d_i[idx]    = dd;
    en_i[idx]   = e;
    up_i[idx]   = u;
    #1;
    predict_all();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      clr_i[k] = 1'b0; load_i[k] = 1'b0; d_i[k] = '0; en_i[k] = 1'b0; up_i[k] = 1'b1;
      mq[k] = 0; movf[k] = 1'b0;
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (q_o[k] !== 4'd0 || ovf_o[k] !== 1'b0 || tc_o[k] !== 1'b0) begin
        n_err++;
        $display("FAIL reset inst%0d: got q=%0d ovf=%b tc=%b expected 0/0/0",
                 k, q_o[k], ovf_o[k], tc_o[k]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    step(0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic test_wrap_up();
    for (int i = 0; i < 12; i++) step(0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    n_cmp++;
    if (q_o[0] !== 4'd2) begin
      n_err++;
      $display("FAIL wrap_up_final: got %0d expected 2", q_o[0]);
    end
    step(0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic test_wrap_down();
    for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    n_cmp++;
    if (q_o[0] !== 4'd7) begin
      n_err++;
      $display("FAIL wrap_down_final: got %0d expected 7", q_o[0]);
    end
    step(0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    step(0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 12; i++) step(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    n_cmp++;
    if (q_o[1] !== 4'd9 || ovf_o[1] !== 1'b1) begin
      n_err++;
      $display("FAIL sat_hold: got q=%0d ovf=%b expected 9/1", q_o[1], ovf_o[1]);
    end
    step(1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) step(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    step(1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic test_load();
    step(0, 1'b0, 1'b1, 4'd13, 1'b1, 1'b1);
    n_cmp++;
    if (q_o[0] !== 4'd9) begin
      n_err++;
      $display("FAIL load_clamp: got %0d expected 9", q_o[0]);
    end
    step(0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0);
    step(0, 1'b1, 1'b1, 4'd7, 1'b1, 1'b1);
    step(0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) step(0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (q_o[k] !== 4'd0 || ovf_o[k] !== 1'b0) begin
        n_err++;
        $display("FAIL async_reset inst%0d: got q=%0d ovf=%b expected 0/0", k, q_o[k], ovf_o[k]);
      end
      mq[k] = 0;
      movf[k] = 1'b0;
    end
    #1;
    rst = 1'b1;
    predict_all();
    @(posedge clk);
    #1;
    drain();
    step(0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic test_cascade();
    for (int i = 0; i < 40; i++) step(2, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    n_cmp++;
    if (q_o[2] !== 4'd8 || q_o[3] !== 4'd2) begin
      n_err++;
      $display("FAIL cascade_final: got lo=%0d hi=%0d expected 8/2", q_o[2], q_o[3]);
    end
    step(2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_load();
    test_async_reset();
    test_cascade();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
